// File: rtl/pc_ras_unit_if.sv
// Fetch-stage PC / return-address-stack bus: control and operand inputs
// from decode/execute, PC and stack status outputs back to the pipeline.
interface pc_ras_unit_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic             pcenable;
    logic [1:0]       pcsrc;
    logic [WIDTH-1:0] rdat1;
    logic             branch;
    logic             bne;
    logic             zero_f;
    logic [15:0]      branch_imm;
    logic [WIDTH-1:0] branch_pc4;
    logic [25:0]      jaddr;
    logic             link;
    logic             jr_ra;
    logic [WIDTH-1:0] pcout;
    logic [WIDTH-1:0] pcplus4;
    logic [WIDTH-1:0] ras_top;
    logic             ras_empty;
    logic             ras_full;
    logic             ras_overflow;
    logic             ras_mismatch;

    // Pipeline side: drives control/operands, observes PC and stack status.
    modport master (
        output pcenable, pcsrc, rdat1, branch, bne, zero_f, branch_imm,
               branch_pc4, jaddr, link, jr_ra,
        input  pcout, pcplus4, ras_top, ras_empty, ras_full,
               ras_overflow, ras_mismatch
    );

    // PC unit side.
    modport slave (
        input  pcenable, pcsrc, rdat1, branch, bne, zero_f, branch_imm,
               branch_pc4, jaddr, link, jr_ra,
        output pcout, pcplus4, ras_top, ras_empty, ras_full,
               ras_overflow, ras_mismatch
    );
endinterface

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection and a circular return-address
// stack. JAL pushes its link address; JR $31 pops and reports whether the
// stacked address agreed with the register value. The stack never steers
// the PC: the JR target is always the register operand.
module pc_ras_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input logic          CLK,
    input logic          RST,
    pc_ras_unit_if.slave bus
);
    localparam int unsigned     PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pcout_q, pcout_d;
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [WIDTH-1:0] stack_d [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d, top_inc_s;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             mis_q, mis_d;

    logic [WIDTH-1:0] pcplus4_s, pcnext_s, br_off_s, jr_tgt_s, ras_top_s;
    logic             taken_s, push_s, pop_s;
    logic             unused_ok_s;

    // Low two bits of the JR operand are discarded (word-aligned target).
    assign unused_ok_s = ^bus.rdat1[1:0];

    // Values derived purely from state: PC+4 and the visible top of stack.
    always_comb begin
        pcplus4_s = pcout_q + WIDTH'(4);
        if (count_q == {CNT_W{1'b0}}) begin
            ras_top_s = {WIDTH{1'b0}};
        end else begin
            ras_top_s = stack_q[top_q];
        end
    end

    // Next-PC mux over sequential, JR, conditional branch and J/JAL sources.
    always_comb begin
        br_off_s = {{(WIDTH-18){bus.branch_imm[15]}}, bus.branch_imm, 2'b00};
        jr_tgt_s = {bus.rdat1[WIDTH-1:2], 2'b00};
        taken_s  = bus.branch & (bus.bne ? ~bus.zero_f : bus.zero_f);
        pcnext_s = pcplus4_s;
        case (bus.pcsrc)
            2'b00: pcnext_s = pcplus4_s;
            2'b01: pcnext_s = jr_tgt_s;
            2'b10: begin
                if (taken_s) begin
                    pcnext_s = bus.branch_pc4 + br_off_s;
                end else begin
                    pcnext_s = pcplus4_s;
                end
            end
            2'b11: pcnext_s = {pcplus4_s[WIDTH-1:28], bus.jaddr, 2'b00};
            default: pcnext_s = pcplus4_s;
        endcase
    end

    // Next state for PC, stack, pointer/count and the one-cycle status pulses.
    always_comb begin
        pcout_d   = pcout_q;
        stack_d   = stack_q;
        top_d     = top_q;
        count_d   = count_q;
        ovf_d     = 1'b0;
        mis_d     = 1'b0;
        top_inc_s = top_q + PTR_W'(1);
        push_s    = bus.pcenable & (bus.pcsrc == 2'b11) & bus.link;
        pop_s     = bus.pcenable & (bus.pcsrc == 2'b01) & bus.jr_ra;

        if (bus.pcenable) begin
            pcout_d = pcnext_s;
        end else begin
            pcout_d = pcout_q;
        end

        if (push_s) begin
            // A full stack keeps its count; the write lands on the oldest slot.
            stack_d[top_inc_s] = pcplus4_s;
            top_d              = top_inc_s;
            if (count_q == DEPTH_C) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else if (pop_s) begin
            if (count_q == {CNT_W{1'b0}}) begin
                mis_d = 1'b1;
            end else begin
                mis_d   = (ras_top_s != jr_tgt_s);
                count_d = count_q - CNT_W'(1);
                top_d   = top_q - PTR_W'(1);
            end
        end else begin
            top_d = top_q;
        end
    end

    // State registers with asynchronous reset to the power-on state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pcout_q <= RESET_PC;
            top_q   <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            ovf_q   <= 1'b0;
            mis_q   <= 1'b0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                stack_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            pcout_q <= pcout_d;
            top_q   <= top_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            mis_q   <= mis_d;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                stack_q[i] <= stack_d[i];
            end
        end
    end

    assign bus.pcout        = pcout_q;
    assign bus.pcplus4      = pcplus4_s;
    assign bus.ras_top      = ras_top_s;
    assign bus.ras_empty    = (count_q == {CNT_W{1'b0}});
    assign bus.ras_full     = (count_q == DEPTH_C);
    assign bus.ras_overflow = ovf_q;
    assign bus.ras_mismatch = mis_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed bench for pc_ras_unit: stimulus queues hand-computed expected
// outputs, a separate monitor pops and compares them against the DUT.
module tb_pc_ras_unit;
    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    pc_ras_unit_if #(.WIDTH(32)) bus ();

    pc_ras_unit #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000),
        .RAS_DEPTH(4)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] top;
        logic        empty;
        logic        full;
        logic        ovf;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    event exp_ev;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s.%s: got %h expected %h", nm, f, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: compare every queued expectation shortly after it is posted.
    initial begin
        exp_t e;
        forever begin
            @(exp_ev);
            #1;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.name, "pcout",    bus.pcout,              e.pc);
                chk(e.name, "pcplus4",  bus.pcplus4,            e.pc + 32'd4);
                chk(e.name, "ras_top",  bus.ras_top,            e.top);
                chk(e.name, "empty",    {31'd0, bus.ras_empty}, {31'd0, e.empty});
                chk(e.name, "full",     {31'd0, bus.ras_full},  {31'd0, e.full});
                chk(e.name, "overflow", {31'd0, bus.ras_overflow}, {31'd0, e.ovf});
                chk(e.name, "mismatch", {31'd0, bus.ras_mismatch}, {31'd0, e.mis});
            end
        end
    end

    task automatic idle();
        bus.pcenable   = 1'b1;
        bus.pcsrc      = 2'b00;
        bus.rdat1      = 32'd0;
        bus.branch     = 1'b0;
        bus.bne        = 1'b0;
        bus.zero_f     = 1'b0;
        bus.branch_imm = 16'd0;
        bus.branch_pc4 = 32'd0;
        bus.jaddr      = 26'd0;
        bus.link       = 1'b0;
        bus.jr_ra      = 1'b0;
    endtask

    task automatic expect_now(input string nm, input logic [31:0] pc, input logic [31:0] top,
                              input logic empty, input logic full, input logic ovf, input logic mis);
        exp_t e;
        e.name = nm; e.pc = pc; e.top = top;
        e.empty = empty; e.full = full; e.ovf = ovf; e.mis = mis;
        exp_q.push_back(e);
        -> exp_ev;
    endtask

    // One clock with the currently driven inputs, then return to idle inputs.
    task automatic cyc(input string nm, input logic [31:0] pc, input logic [31:0] top,
                       input logic empty, input logic full, input logic ovf, input logic mis);
        @(posedge CLK);
        expect_now(nm, pc, top, empty, full, ovf, mis);
        @(negedge CLK);
        idle();
    endtask

    task automatic jal(input logic [25:0] ja);
        bus.pcsrc = 2'b11; bus.jaddr = ja; bus.link = 1'b1;
    endtask

    task automatic jr(input logic [31:0] r, input logic ra);
        bus.pcsrc = 2'b01; bus.rdat1 = r; bus.jr_ra = ra;
    endtask

    task automatic br(input logic b, input logic ne, input logic z,
                      input logic [31:0] pc4, input logic [15:0] imm);
        bus.pcsrc = 2'b10; bus.branch = b; bus.bne = ne; bus.zero_f = z;
        bus.branch_pc4 = pc4; bus.branch_imm = imm;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        RST = 1'b1;
        #12;
        expect_now("reset", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // Sequential fetch; link/jr_ra are ignored under pcsrc 00.
        cyc("seq1", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("seq2", 32'h8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.link = 1'b1; bus.jr_ra = 1'b1;
        cyc("seq3", 32'hC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Branch mix.
        br(1'b1, 1'b0, 1'b1, 32'h100, 16'hFFFE);
        cyc("beq_taken", 32'hF8, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        br(1'b1, 1'b1, 1'b1, 32'h500, 16'h0040);
        cyc("bne_not_taken", 32'hFC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        br(1'b0, 1'b0, 1'b1, 32'h500, 16'h0040);
        cyc("not_branch", 32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        br(1'b1, 1'b1, 1'b0, 32'h200, 16'h0010);
        cyc("bne_taken", 32'h240, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Stall with a JAL presented: nothing moves.
        bus.pcenable = 1'b0; jal(26'h123);
        cyc("stall1", 32'h240, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.pcenable = 1'b0; jal(26'h123);
        cyc("stall2", 32'h240, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // JR through a non-$31 register, target low bits masked.
        jr(32'h3F, 1'b0);
        cyc("jr_plain", 32'h3C, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("seq_40", 32'h40, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // JAL/JR pair.
        jal(26'h10);
        cyc("jal", 32'h40, 32'h44, 1'b0, 1'b0, 1'b0, 1'b0);
        jr(32'h44, 1'b1);
        cyc("jr_ra_hit", 32'h44, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Overflow: five pushes into four entries.
        jal(26'h100); cyc("push1", 32'h400,  32'h48,   1'b0, 1'b0, 1'b0, 1'b0);
        jal(26'h200); cyc("push2", 32'h800,  32'h404,  1'b0, 1'b0, 1'b0, 1'b0);
        jal(26'h300); cyc("push3", 32'hC00,  32'h804,  1'b0, 1'b0, 1'b0, 1'b0);
        jal(26'h400); cyc("push4", 32'h1000, 32'hC04,  1'b0, 1'b1, 1'b0, 1'b0);
        jal(26'h500); cyc("push5", 32'h1400, 32'h1004, 1'b0, 1'b1, 1'b1, 1'b0);
        jr(32'h1004, 1'b1); cyc("pop1", 32'h1004, 32'hC04, 1'b0, 1'b0, 1'b0, 1'b0);
        jr(32'hC04, 1'b1);  cyc("pop2", 32'hC04,  32'h804, 1'b0, 1'b0, 1'b0, 1'b0);
        jr(32'h804, 1'b1);  cyc("pop3", 32'h804,  32'h404, 1'b0, 1'b0, 1'b0, 1'b0);
        jr(32'h404, 1'b1);  cyc("pop4", 32'h404,  32'h0,   1'b1, 1'b0, 1'b0, 1'b0);
        jr(32'h48, 1'b1);   cyc("pop_empty", 32'h48, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        cyc("pulse_clear", 32'h4C, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Mismatching pop.
        jal(26'h10);
        cyc("jal2", 32'h40, 32'h50, 1'b0, 1'b0, 1'b0, 1'b0);
        jr(32'h80, 1'b1);
        cyc("jr_ra_miss", 32'h80, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1);

        // J keeps upper PC bits; PC wraps past the top of the address space.
        jr(32'hA000_0000, 1'b0);
        cyc("jr_high", 32'hA000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.pcsrc = 2'b11; bus.jaddr = 26'h3FF_FFFF; bus.link = 1'b0;
        cyc("j_nolink", 32'hAFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("seq_b", 32'hB000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        jr(32'hFFFF_FFFC, 1'b0);
        cyc("jr_top", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc("wrap", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Async reset between edges with a push pending.
        jal(26'h20); cyc("apush1", 32'h80,  32'h4,  1'b0, 1'b0, 1'b0, 1'b0);
        jal(26'h40); cyc("apush2", 32'h100, 32'h84, 1'b0, 1'b0, 1'b0, 1'b0);
        jal(26'h77);
        #2;
        RST = 1'b1;
        #1;
        expect_now("async_rst", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        jal(26'h77);
        cyc("rst_hold", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        cyc("post_rst", 32'h4, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge CLK);
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end else begin
            n_pass++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
